// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_uart_tx : UART transmitter that pops bytes from a TX FIFO and
//                serialises start / data LSB-first / [parity] / stop.
// Revision     : 1.0
// ----------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int data_width     = 8,
  parameter int clocks_per_bit = 16,
  parameter int stop_bits      = 1,
  parameter int parity_enable  = 0,
  parameter int parity_odd     = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [data_width-1:0] fifo_data_in,
  output logic                  fifo_read_enable,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BAUD_W = $clog2(clocks_per_bit);
  localparam int BIT_W  = $clog2(data_width + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(clocks_per_bit - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE   = BAUD_W'(clocks_per_bit - 2);
  localparam logic [BIT_W-1:0]  DATA_LAST  = BIT_W'(data_width - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST  = BIT_W'(stop_bits - 1);
  localparam logic              ODD_SEED   = (parity_odd != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

  state_t                state;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [data_width-1:0] shift_reg;
  logic                  parity_bit;

  logic                  baud_last;
  logic                  stop_last_bit;
  logic                  pop_now;
  logic [data_width-1:0] shift_next;

  assign baud_last     = (baud_cnt == BAUD_LAST);
  assign stop_last_bit = (bit_cnt == STOP_LAST);
  assign pop_now       = enable && !fifo_empty;
  assign shift_next    = shift_reg >> 1;

  // All outputs are registered: each branch loads the value the line/flags
  // must carry in the cycle that follows the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      baud_cnt         <= '0;
      bit_cnt          <= '0;
      shift_reg        <= '0;
      parity_bit       <= 1'b0;
      tx               <= 1'b1;
      busy             <= 1'b0;
      fifo_read_enable <= 1'b0;
      frame_done       <= 1'b0;
    end else begin
      fifo_read_enable <= 1'b0;
      frame_done       <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop_now) begin
            state            <= POP;
            busy             <= 1'b1;
            fifo_read_enable <= 1'b1;
          end
        end
        POP: begin
          state <= LOAD;
        end
        LOAD: begin
          shift_reg  <= fifo_data_in;
          parity_bit <= (^fifo_data_in) ^ ODD_SEED;
          baud_cnt   <= '0;
          bit_cnt    <= '0;
          tx         <= 1'b0;
          state      <= START;
        end
        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            tx       <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (parity_enable != 0) begin
                tx    <= parity_bit;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              shift_reg <= shift_next;
              tx        <= shift_next[0];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          tx <= 1'b1;
          // Raised one edge early so the pulse lands on the final stop cycle.
          frame_done <= (baud_cnt == BAUD_PRE) && stop_last_bit;
          if (baud_last) begin
            baud_cnt <= '0;
            if (stop_last_bit) begin
              bit_cnt <= '0;
              if (pop_now) begin
                state            <= POP;
                fifo_read_enable <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// tb_fifo_uart_tx : randomized scoreboard bench; three DUTs cover parity
// off, even parity and odd parity under identical stimulus.
module tb_fifo_uart_tx;

  localparam int CPB    = 4;
  localparam int DW     = 8;
  localparam int NWORDS = 96;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  int         avail;
  logic [7:0] src [NWORDS];
  int         tests = 0;
  int         fails = 0;
  logic [2:0] idle_v;
  logic [2:0] pop_v;
  logic [2:0] tx_v;
  logic [2:0] busy_v;

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[dut%0d] t=%0t got %0h want %0h", name, idx, $time, act, exp);
    end
  endtask

  // Line level expected in bit slot 'slot' of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int slot,
                                     input int pe, input int po);
    if (slot == 0) return 1'b0;
    if (slot <= DW) return b[slot-1];
    if (pe != 0 && slot == DW + 1) return (^b) ^ (po != 0);
    return 1'b1;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int PE = (gi >= 1) ? 1 : 0;
    localparam int PO = (gi == 2) ? 1 : 0;
    localparam int L  = (1 + DW + PE + 1) * CPB;

    logic       empty, fre, tx, busy, fd;
    logic [7:0] fdata = 8'h00;
    int         rd = 0;
    int         pushed = 0;
    logic [7:0] exp_q [$];
    logic [7:0] cur = 8'h00;
    int         pos = 0;
    logic       active = 1'b0;
    logic       can_pop = 1'b0;
    logic       prev_en = 1'b0;
    logic       prev_empty = 1'b1;

    assign empty       = (rd >= avail);
    assign idle_v[gi]  = empty && !busy;
    assign pop_v[gi]   = fre;
    assign tx_v[gi]    = tx;
    assign busy_v[gi]  = busy;

    fifo_uart_tx #(
      .data_width(DW), .clocks_per_bit(CPB), .stop_bits(1),
      .parity_enable(PE), .parity_odd(PO)
    ) u_dut (
      .clock(clk), .reset(rst), .enable(enable), .fifo_empty(empty),
      .fifo_data_in(fdata), .fifo_read_enable(fre), .tx(tx),
      .busy(busy), .frame_done(fd)
    );

    // FIFO model: registered read data, garbage on every other cycle.
    always @(posedge clk) begin
      while (pushed < avail) begin
        exp_q.push_back(src[pushed]);
        pushed++;
      end
      if (fre) begin
        fdata <= src[rd];
        rd    <= rd + 1;
      end else begin
        fdata <= 8'($urandom);
      end
    end

    // Monitor: a pop is due one cycle after an idle/last-stop cycle that saw
    // enable && !empty; the frame then runs POP, LOAD and L line cycles.
    always @(negedge clk) begin
      logic exp_fre, exp_tx, exp_fd;
      if (rst) begin
        check("rst_tx", gi, tx, 1);
        check("rst_busy", gi, busy, 0);
        check("rst_pop", gi, fre, 0);
        check("rst_done", gi, fd, 0);
        active  = 1'b0;
        can_pop = 1'b0;
      end else begin
        exp_fre = can_pop && prev_en && !prev_empty;
        if (active) pos++;
        if (exp_fre) begin
          check("queue_nonempty", gi, exp_q.size() != 0, 1);
          active = 1'b1;
          pos    = 0;
          cur    = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        end
        exp_tx = 1'b1;
        exp_fd = 1'b0;
        if (active && pos >= 2) begin
          exp_tx = frame_bit(cur, (pos - 2) / CPB, PE, PO);
          exp_fd = (pos - 2 == L - 1);
        end
        check("pop", gi, fre, exp_fre);
        check("tx", gi, tx, exp_tx);
        check("busy", gi, busy, active);
        check("frame_done", gi, fd, exp_fd);
        if (active && pos - 2 == L - 1) active = 1'b0;
        can_pop = !active;
      end
      prev_en    = enable;
      prev_empty = empty;
    end
  end

  task automatic wait_pop0(output logic seen);
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(posedge clk); #1;
      if (pop_v[0]) seen = 1'b1;
    end
  endtask

  initial begin
    logic seen;
    for (int i = 0; i < NWORDS; i++) src[i] = 8'($urandom);
    src[0] = 8'h55; src[1] = 8'h01; src[2] = 8'h80; src[3] = 8'h07; src[4] = 8'h00;
    rst = 1'b1; enable = 1'b1; avail = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    repeat (60) @(posedge clk);
    #1 avail = 4;
    repeat (150) @(posedge clk);
    #1 enable = 1'b0; avail = 6;
    repeat (50) @(posedge clk);
    #1 enable = 1'b1;
    wait_pop0(seen);
    check("pop0_seen_a", 0, seen, 1);
    repeat (15) @(posedge clk);
    #1 enable = 1'b0;
    repeat (80) @(posedge clk);
    #1 enable = 1'b1; avail = 9;
    wait_pop0(seen);
    check("pop0_seen_b", 0, seen, 1);
    // Land inside data bit 3 of DUT 0, then reset asynchronously.
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_tx", 0, tx_v, 3'b111);
    check("async_busy", 0, busy_v, 3'b000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(29) == 0 && avail < NWORDS) avail++;
      if ($urandom_range(39) == 0) enable = ($urandom_range(3) != 0);
      rst = ($urandom_range(999) == 0);
    end

    #0 rst = 1'b0; enable = 1'b1;
    for (int c = 0; c < 8000 && idle_v != 3'b111; c++) @(posedge clk);
    #1;
    check("drained", 0, idle_v, 3'b111);
    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
